// File: rtl/cmsdk_ahb_timeout_recovery.sv
// Recovery sequencer beside an AHB-Lite timeout monitor: counts timeout events,
// raises a sticky IRQ, and issues bounded, retried reset pulses to a hung slave.
module cmsdk_ahb_timeout_recovery #(
  parameter int RST_DELAY = 64,
  parameter int RST_LEN   = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 TIMEOUT,
  input  logic                 ENABLE,
  input  logic                 IRQCLR,
  input  logic                 CNTCLR,
  output logic                 SLVRSTREQn,
  output logic                 IRQ,
  output logic                 FAIL,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] TOCOUNT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_RESET  = 3'd2,
    S_SETTLE = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [9:0] DELAY_LAST = 10'(RST_DELAY - 1);
  localparam logic [9:0] LEN_LAST   = 10'(RST_LEN - 1);
  localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

  state_t               state_q, state_d;
  logic [9:0]           timer_q, timer_d;
  logic [3:0]           retry_q, retry_d;
  logic                 timeout_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 irq_q, irq_d;
  logic                 slvrst_n_q, fail_q, busy_q;
  logic                 evt;

  assign evt = TIMEOUT & ~timeout_q;

  // Event counter saturates; a clear coincident with an event counts that event.
  always_comb begin
    cnt_d = cnt_q;
    if (CNTCLR)
      cnt_d = CNT_WIDTH'(evt);
    else if (evt && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (TIMEOUT && ENABLE) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (!TIMEOUT || !ENABLE) begin
          state_d = S_IDLE;
        end else if (timer_q == DELAY_LAST) begin
          state_d = S_RESET;
          retry_d = retry_q + 4'd1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      // The pulse runs to completion whatever TIMEOUT/ENABLE do meanwhile.
      S_RESET: begin
        if (timer_q == LEN_LAST) begin
          state_d = S_SETTLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      S_SETTLE: begin
        if (!TIMEOUT) begin
          state_d = S_IDLE;
        end else if (timer_q == DELAY_LAST) begin
          if (retry_q < RETRY_MAX) begin
            state_d = S_RESET;
            retry_d = retry_q + 4'd1;
            timer_d = '0;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end
      S_FAIL: begin
        if (IRQCLR && !TIMEOUT)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      timer_d = '0;
      retry_d = '0;
    end
  end

  // Set beats clear when both land in the same cycle.
  always_comb begin
    irq_d = irq_q;
    if (evt || (state_d == S_FAIL && state_q != S_FAIL))
      irq_d = 1'b1;
    else if (IRQCLR)
      irq_d = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
      slvrst_n_q <= 1'b1;
      fail_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      timeout_q  <= TIMEOUT;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
      slvrst_n_q <= (state_d != S_RESET);
      fail_q     <= (state_d == S_FAIL);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign SLVRSTREQn = slvrst_n_q;
  assign IRQ        = irq_q;
  assign FAIL       = fail_q;
  assign BUSY       = busy_q;
  assign TOCOUNT    = cnt_q;

endmodule

// File: doc/cmsdk_ahb_timeout_recovery.md
# cmsdk_ahb_timeout_recovery

Recovery sequencer for an AHB-Lite timeout monitor. It counts timeout events and raises an interrupt. When the monitor stays in its timeout state, the block issues bounded, retried reset pulses to the hung slave. It sits beside the timeout monitor: it takes the monitor's TIMEOUT status and drives the slave's reset request.

## Interface
Parameters:
- RST_DELAY, 64: consecutive TIMEOUT-high cycles before a reset pulse; also the settle window after each pulse. Range 2..1024.
- RST_LEN, 4: reset pulse length in cycles. Range 1..256.
- MAX_RETRY, 3: maximum reset pulses per episode. Range 1..15.
- CNT_WIDTH, 8: width of the event counter. Range 1..16.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- TIMEOUT  in  1  timeout status from the monitor
- ENABLE  in  1  auto-recovery enable
- IRQCLR  in  1  clears IRQ; exits FAIL
- CNTCLR  in  1  clears TOCOUNT
- SLVRSTREQn  out  1  registered active-low slave reset request
- IRQ  out  1  sticky interrupt
- FAIL  out  1  retries exhausted
- BUSY  out  1  state is not IDLE
- TOCOUNT  out  CNT_WIDTH  saturating count of timeout events

## Operation
- Internal state: timeout_q (previous TIMEOUT), a 10-bit timer, a 4-bit retry counter, and a 3-bit FSM with states IDLE, WAIT, RESET, SETTLE, FAIL.
- Event detection:
  - An event is `TIMEOUT & ~timeout_q`.
  - Events are counted regardless of state or ENABLE.
  - TOCOUNT increments by 1 per event and saturates at all-ones.
- Counter clear:
  - CNTCLR alone sets TOCOUNT to 0.
  - CNTCLR together with an event sets TOCOUNT to 1.
- IRQ:
  - Set by an event or by entry to FAIL.
  - Cleared by IRQCLR.
  - If set and clear occur in the same cycle, set wins.
- IDLE: go to WAIT when TIMEOUT=1 and ENABLE=1. The timer is set to 0.
- WAIT:
  - The timer increments each cycle.
  - TIMEOUT=0 or ENABLE=0: go to IDLE.
  - Timer == RST_DELAY-1 with TIMEOUT=1: go to RESET. The retry counter increments and the timer is set to 0.
- RESET:
  - SLVRSTREQn=0 for exactly RST_LEN cycles. The pulse is never truncated, even if ENABLE or TIMEOUT changes.
  - Timer == RST_LEN-1: go to SETTLE and set the timer to 0.
- SETTLE:
  - The timer increments each cycle.
  - TIMEOUT=0: go to IDLE.
  - Timer == RST_DELAY-1 with TIMEOUT=1: if the retry counter < MAX_RETRY, go to RESET (retry counter increments); otherwise go to FAIL.
  - ENABLE is ignored in SETTLE.
- FAIL:
  - FAIL=1 and SLVRSTREQn=1.
  - Go to IDLE when IRQCLR=1 and TIMEOUT=0 in the same cycle. FAIL then clears.
- Entering IDLE clears the retry counter and the timer.
- Outputs:
  - SLVRSTREQn = ~(state==RESET) and is driven from a flop; no glitches.
  - BUSY = (state != IDLE).

## Timing
- Reset values:
  - SLVRSTREQn=1, IRQ=0, FAIL=0, BUSY=0, TOCOUNT=0.
  - State IDLE; timer, retry counter and timeout_q all 0.
- Asserting HRESETn mid-sequence forces SLVRSTREQn=1 immediately (asynchronous), ending any pulse.
- Edge 0 is the first rising edge that samples TIMEOUT=1.
  - IRQ=1 and TOCOUNT updated after edge 0.
  - BUSY=1 after edge 0.
  - SLVRSTREQn falls after edge RST_DELAY and rises after edge RST_DELAY+RST_LEN.
- A retried pulse falls RST_DELAY cycles after the previous pulse rises.
- FAIL asserts RST_DELAY cycles after the last pulse rises.
- TIMEOUT dropping in the same cycle the WAIT timer expires: go to IDLE; no pulse.

## Test plan
All scenarios use RST_DELAY=8, RST_LEN=4, MAX_RETRY=2, CNT_WIDTH=2 unless stated.
- TIMEOUT high for 5 cycles, then low, ENABLE=1 -> SLVRSTREQn stays 1, IRQ=1, TOCOUNT=1, BUSY returns to 0.
- TIMEOUT held high, dropped 3 cycles after the pulse ends -> exactly one pulse, low after edges 8..11, then IDLE; FAIL=0.
- TIMEOUT stuck high ->
  - Pulses low after edges 8..11 and 20..23; FAIL=1 after edge 32.
  - IRQCLR with TIMEOUT=1 leaves FAIL=1.
  - IRQCLR with TIMEOUT=0 -> IDLE, FAIL=0, IRQ=0.
- ENABLE=0, TIMEOUT high for 100 cycles -> SLVRSTREQn=1 throughout, BUSY=0, TOCOUNT=1, IRQ=1.
- HRESETn asserted during the second cycle of the pulse -> SLVRSTREQn=1 asynchronously; all outputs at reset values.
- Five TIMEOUT events -> TOCOUNT=3 (saturated). CNTCLR coincident with a sixth event -> TOCOUNT=1. IRQCLR coincident with an event -> IRQ stays 1.
